// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the register-file controller
package regfile_pkg;

  localparam int NUM_REGS = 4;
  localparam int IDX_W    = 2;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_COPY  = 2'b10,
    OP_SWAP  = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EX1  = 2'b01,
    EX2  = 2'b10,
    EX3  = 2'b11
  } state_e;

  // Source of the register-file write data in the current exec cycle
  typedef enum logic [1:0] {
    WR_ZERO    = 2'b00,
    WR_LATCHED = 2'b01,
    WR_RDDATA  = 2'b10,
    WR_TEMP    = 2'b11
  } wr_src_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/regfile_ctrl_if.sv
// rtl/regfile_ctrl_if.sv - requester and register-file signal bundle for regfile_ctrl
interface regfile_ctrl_if #(parameter int N = 4);
  import regfile_pkg::*;

  logic [1:0]                 iReq;
  logic [1:0][1:0]            iOp;
  logic [1:0][IDX_W-1:0]      iSrc;
  logic [1:0][IDX_W-1:0]      iDst;
  logic [1:0][N-1:0]          iData;
  logic [1:0]                 oGnt;
  logic [1:0]                 oAck;
  logic [N-1:0]               oRdData;
  logic                       oBusy;
  logic [NUM_REGS-1:0]        oLoad;
  logic [N-1:0]               oWrData;
  logic [IDX_W-1:0]           oRdIdx;
  logic [N-1:0]               iRdData;

  modport slave (
    input  iReq, iOp, iSrc, iDst, iData, iRdData,
    output oGnt, oAck, oRdData, oBusy, oLoad, oWrData, oRdIdx
  );

  modport master (
    output iReq, iOp, iSrc, iDst, iData, iRdData,
    input  oGnt, oAck, oRdData, oBusy, oLoad, oWrData, oRdIdx
  );

endinterface

// File: rtl/regfile_ctrl_arb.sv
// rtl/regfile_ctrl_arb.sv - two-requester round-robin arbiter
module rr_arbiter2 (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] iReq,
  input  logic       iUpdate,
  output logic [1:0] oGnt
);

  // ptr names the requester that wins when both are requesting
  logic ptr;

  // Lone requester always wins; on contention the pointer side wins
  always_comb begin
    oGnt = 2'b00;
    case (iReq)
      2'b01:   oGnt = 2'b01;
      2'b10:   oGnt = 2'b10;
      2'b11:   oGnt = ptr ? 2'b10 : 2'b01;
      default: oGnt = 2'b00;
    endcase
  end

  // After every accepted grant the pointer moves to the other requester
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ptr <= 1'b0;
    end else if (iUpdate && (|oGnt)) begin
      ptr <= oGnt[0];
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - arbitrated READ/WRITE/COPY/SWAP sequencer for a 4-entry register file
module regfile_ctrl
  import regfile_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  regfile_ctrl_if.slave  bus
);

  state_e              state;
  opcode_e             op_q;
  logic [IDX_W-1:0]    src_q;
  logic [IDX_W-1:0]    dst_q;
  logic [N-1:0]        data_q;
  logic [N-1:0]        temp_q;
  logic [1:0]          owner_q;

  logic [1:0]          gnt_q;
  logic [1:0]          ack_q;
  logic                busy_q;
  logic [NUM_REGS-1:0] load_q;
  logic [IDX_W-1:0]    rd_idx_q;
  wr_src_e             wr_sel;
  logic                rd_valid;

  logic [1:0]          arb_gnt;
  logic                sel;
  opcode_e             new_op;
  logic [IDX_W-1:0]    new_src;
  logic [IDX_W-1:0]    new_dst;
  logic [N-1:0]        new_data;

  // The arbiter only advances when a grant is actually taken in IDLE
  rr_arbiter2 u_arb (
    .Clk     (Clk),
    .Reset   (Reset),
    .iReq    (bus.iReq),
    .iUpdate (state == IDLE),
    .oGnt    (arb_gnt)
  );

  assign sel      = arb_gnt[1];
  assign new_op   = opcode_e'(bus.iOp[sel]);
  assign new_src  = bus.iSrc[sel];
  assign new_dst  = bus.iDst[sel];
  assign new_data = bus.iData[sel];

  // Sequencer: control outputs are registered for the cycle being entered;
  // only read-data paths stay combinational through the external read mux
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      op_q     <= OP_READ;
      src_q    <= '0;
      dst_q    <= '0;
      data_q   <= '0;
      temp_q   <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      load_q   <= '0;
      rd_idx_q <= '0;
      wr_sel   <= WR_ZERO;
      rd_valid <= 1'b0;
    end else begin
      gnt_q    <= '0;
      ack_q    <= '0;
      busy_q   <= 1'b0;
      load_q   <= '0;
      rd_idx_q <= '0;
      wr_sel   <= WR_ZERO;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (|arb_gnt) begin
            owner_q <= arb_gnt;
            op_q    <= new_op;
            src_q   <= new_src;
            dst_q   <= new_dst;
            data_q  <= new_data;
            gnt_q   <= arb_gnt;
            busy_q  <= 1'b1;
            state   <= EX1;
            case (new_op)
              OP_READ: begin
                rd_idx_q <= new_src;
                rd_valid <= 1'b1;
                ack_q    <= arb_gnt;
              end
              OP_WRITE: begin
                load_q <= reg_onehot(new_dst);
                wr_sel <= WR_LATCHED;
                ack_q  <= arb_gnt;
              end
              OP_COPY: begin
                rd_idx_q <= new_src;
                load_q   <= reg_onehot(new_dst);
                wr_sel   <= WR_RDDATA;
                ack_q    <= arb_gnt;
              end
              default: begin
                rd_idx_q <= new_src;
              end
            endcase
          end
        end
        EX1: begin
          if (op_q == OP_SWAP) begin
            temp_q   <= bus.iRdData;
            gnt_q    <= owner_q;
            busy_q   <= 1'b1;
            rd_idx_q <= dst_q;
            load_q   <= reg_onehot(src_q);
            wr_sel   <= WR_RDDATA;
            state    <= EX2;
          end else begin
            state <= IDLE;
          end
        end
        EX2: begin
          gnt_q  <= owner_q;
          busy_q <= 1'b1;
          load_q <= reg_onehot(dst_q);
          wr_sel <= WR_TEMP;
          ack_q  <= owner_q;
          state  <= EX3;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Write-data mux selected by the registered source tag
  always_comb begin
    bus.oWrData = '0;
    case (wr_sel)
      WR_LATCHED: bus.oWrData = data_q;
      WR_RDDATA:  bus.oWrData = bus.iRdData;
      WR_TEMP:    bus.oWrData = temp_q;
      default:    bus.oWrData = '0;
    endcase
  end

  assign bus.oGnt    = gnt_q;
  assign bus.oAck    = ack_q;
  assign bus.oBusy   = busy_q;
  assign bus.oLoad   = load_q;
  assign bus.oRdIdx  = rd_idx_q;
  assign bus.oRdData = rd_valid ? bus.iRdData : '0;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - self-checking bench for regfile_ctrl
module tb_regfile_ctrl;
  import regfile_pkg::*;

  localparam int N = 4;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  always #5 Clk = ~Clk;

  regfile_ctrl_if #(.N(N)) bus();

  regfile_ctrl #(.N(N)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  // Register file driven by the controller
  logic [N-1:0] rf [4] = '{default: '0};
  assign bus.iRdData = rf[bus.oRdIdx];
  always @(posedge Clk) begin
    for (int i = 0; i < 4; i++) if (bus.oLoad[i]) rf[i] <= bus.oWrData;
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs for one cycle
  typedef struct {
    logic [1:0]   gnt;
    logic [1:0]   ack;
    logic         busy;
    logic [3:0]   load;
    logic [N-1:0] wr;
    logic [1:0]   rdidx;
    logic [N-1:0] rd;
  } exp_t;

  function automatic exp_t blank();
    exp_t e;
    e.gnt = 0; e.ack = 0; e.busy = 0; e.load = 0; e.wr = 0; e.rdidx = 0; e.rd = 0;
    return e;
  endfunction

  // Transaction model: a granted op becomes a list of per-cycle expectations
  exp_t         sched[$];
  logic [N-1:0] mregs [4] = '{default: '0};
  int           mptr = 0;

  always @(posedge Clk) begin : model
    exp_t e, e2, e3;
    int k;
    logic [1:0] g, op, s, d;
    logic [N-1:0] dat;
    if (sched.size() > 0) begin
      e = sched.pop_front();
      for (int i = 0; i < 4; i++) if (e.load[i]) mregs[i] = e.wr;
    end else if (!Reset && bus.iReq != 2'b00) begin
      if (bus.iReq == 2'b11) k = mptr;
      else k = bus.iReq[1] ? 1 : 0;
      mptr = (k == 0) ? 1 : 0;
      g = 2'b01 << k;
      op = bus.iOp[k]; s = bus.iSrc[k]; d = bus.iDst[k]; dat = bus.iData[k];
      e = blank(); e.gnt = g; e.busy = 1'b1;
      case (op)
        2'b00: begin e.ack = g; e.rdidx = s; e.rd = mregs[s]; sched.push_back(e); end
        2'b01: begin e.ack = g; e.load = 4'b0001 << d; e.wr = dat; sched.push_back(e); end
        2'b10: begin e.ack = g; e.rdidx = s; e.load = 4'b0001 << d; e.wr = mregs[s]; sched.push_back(e); end
        default: begin
          e.rdidx = s;
          e2 = blank(); e2.gnt = g; e2.busy = 1'b1; e2.rdidx = d; e2.load = 4'b0001 << s; e2.wr = mregs[d];
          e3 = blank(); e3.gnt = g; e3.busy = 1'b1; e3.ack = g; e3.load = 4'b0001 << d; e3.wr = mregs[s];
          sched.push_back(e); sched.push_back(e2); sched.push_back(e3);
        end
      endcase
    end
    if (Reset) begin
      sched.delete();
      mptr = 0;
    end
  end

  // Every-cycle comparison against the model
  always @(negedge Clk) begin : compare
    exp_t x;
    if (chk_en) begin
      x = (sched.size() > 0) ? sched[0] : blank();
      check("cyc_gnt",   bus.oGnt,    x.gnt);
      check("cyc_ack",   bus.oAck,    x.ack);
      check("cyc_busy",  bus.oBusy,   x.busy);
      check("cyc_load",  bus.oLoad,   x.load);
      check("cyc_wr",    bus.oWrData, x.wr);
      check("cyc_rdidx", bus.oRdIdx,  x.rdidx);
      check("cyc_rd",    bus.oRdData, x.rd);
    end
  end

  logic [3:0]   cap_load  [8];
  logic [N-1:0] cap_wr    [8];
  logic [1:0]   cap_ack   [8];
  logic [1:0]   cap_rdidx [8];
  logic [N-1:0] cap_rd    [8];
  int           ncap;

  // Issue one op from requester k and capture every exec cycle until its ack
  task automatic do_op(input int k, input logic [1:0] op, input logic [1:0] s,
                       input logic [1:0] d, input logic [N-1:0] dat);
    bit done;
    done = 1'b0;
    bus.iOp[k] = op; bus.iSrc[k] = s; bus.iDst[k] = d; bus.iData[k] = dat;
    bus.iReq[k] = 1'b1;
    ncap = 0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge Clk);
      if (bus.oGnt != 2'b00 && ncap < 8) begin
        cap_load[ncap] = bus.oLoad; cap_wr[ncap] = bus.oWrData; cap_ack[ncap] = bus.oAck;
        cap_rdidx[ncap] = bus.oRdIdx; cap_rd[ncap] = bus.oRdData;
        ncap++;
      end
      if (bus.oAck[k]) done = 1'b1;
    end
    bus.iReq[k] = 1'b0;
    check("ack_seen", done, 1);
  endtask

  logic [1:0] who [4];
  int         when [4];
  logic [1:0] exp_who [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  int         nack;
  bit         seen;

  initial begin
    bus.iReq = '0; bus.iOp = '0; bus.iSrc = '0; bus.iDst = '0; bus.iData = '0;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    chk_en = 1'b1;
    check("rst_gnt",  bus.oGnt,  0);
    check("rst_busy", bus.oBusy, 0);
    check("rst_load", bus.oLoad, 0);
    check("rst_ack",  bus.oAck,  0);

    // WRITE R2=0xA from requester 0
    do_op(0, OP_WRITE, 2'd0, 2'd2, 4'hA);
    check("w_lat",  ncap, 1);
    check("w_load", cap_load[0], 4'b0100);
    check("w_wr",   cap_wr[0], 4'hA);
    check("w_ack",  cap_ack[0], 2'b01);
    @(negedge Clk);
    check("w_r2", rf[2], 4'hA);

    // R1=0x5, then READ R1 from requester 1
    do_op(0, OP_WRITE, 2'd0, 2'd1, 4'h5);
    do_op(1, OP_READ, 2'd1, 2'd0, 4'h0);
    check("r_rdidx", cap_rdidx[0], 1);
    check("r_rd",    cap_rd[0], 4'h5);
    check("r_ack",   cap_ack[0], 2'b10);
    check("r_load",  cap_load[0], 0);

    // Contention right after reset: order 0,1,0,1, acks two cycles apart
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    bus.iOp[0] = OP_WRITE; bus.iDst[0] = 2'd0; bus.iData[0] = 4'h3;
    bus.iOp[1] = OP_WRITE; bus.iDst[1] = 2'd3; bus.iData[1] = 4'hC;
    bus.iReq = 2'b11;
    nack = 0;
    for (int c = 0; c < 40 && nack < 4; c++) begin
      @(negedge Clk);
      if (bus.oAck != 2'b00) begin
        who[nack] = bus.oAck; when[nack] = cyc; nack++;
      end
    end
    bus.iReq = 2'b00;
    check("rr_count", nack, 4);
    for (int i = 0; i < 4; i++) begin
      check("rr_order", who[i], exp_who[i]);
      if (i > 0) check("rr_gap", when[i] - when[i-1], 2);
    end

    // SWAP R0=0x3 <-> R3=0xC
    do_op(0, OP_SWAP, 2'd0, 2'd3, 4'h0);
    check("sw_lat",    ncap, 3);
    check("sw_ex1_ld", cap_load[0], 0);
    check("sw_ex2_ld", cap_load[1], 4'b0001);
    check("sw_ex2_wr", cap_wr[1], 4'hC);
    check("sw_ex2_ak", cap_ack[1], 0);
    check("sw_ex3_ld", cap_load[2], 4'b1000);
    check("sw_ex3_wr", cap_wr[2], 4'h3);
    check("sw_ex3_ak", cap_ack[2], 2'b01);
    @(negedge Clk);
    check("sw_r0", rf[0], 4'hC);
    check("sw_r3", rf[3], 4'h3);

    // src==dst cases, then an ordinary COPY R1->R0
    do_op(1, OP_COPY, 2'd1, 2'd1, 4'h0);
    check("cs_lat", ncap, 1);
    check("cs_ack", cap_ack[0], 2'b10);
    do_op(0, OP_SWAP, 2'd2, 2'd2, 4'h0);
    check("ss_lat", ncap, 3);
    check("ss_ack", cap_ack[2], 2'b01);
    do_op(1, OP_COPY, 2'd1, 2'd0, 4'h0);
    @(negedge Clk);
    check("cs_r1", rf[1], 4'h5);
    check("ss_r2", rf[2], 4'hA);
    check("cp_r0", rf[0], 4'h5);

    // Reset during EX2 of SWAP R1<->R2 from requester 0
    bus.iOp[0] = OP_SWAP; bus.iSrc[0] = 2'd1; bus.iDst[0] = 2'd2;
    bus.iReq[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge Clk);
      if (bus.oGnt != 2'b00) seen = 1'b1;
    end
    check("x_ex1_gnt", bus.oGnt, 2'b01);
    @(negedge Clk);
    check("x_ex2_ld", bus.oLoad, 4'b0010);
    Reset = 1'b1;
    bus.iReq = 2'b00;
    @(negedge Clk);
    Reset = 1'b0;
    check("x_busy", bus.oBusy, 0);
    for (int c = 0; c < 3; c++) begin
      check("x_ack", bus.oAck, 0);
      check("x_load", bus.oLoad, 0);
      @(negedge Clk);
    end
    check("x_r1", rf[1], 4'hA);
    check("x_r2", rf[2], 4'hA);

    // Pointer must be back on requester 0
    bus.iOp[0] = OP_READ; bus.iSrc[0] = 2'd0;
    bus.iOp[1] = OP_READ; bus.iSrc[1] = 2'd3;
    bus.iReq = 2'b11;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge Clk);
      if (bus.oAck != 2'b00) seen = 1'b1;
    end
    check("ptr_first", bus.oAck, 2'b01);
    check("ptr_rd", bus.oRdData, 4'h5);
    bus.iReq = 2'b00;
    repeat (3) @(negedge Clk);

    for (int i = 0; i < 4; i++) check("rf_model", rf[i], mregs[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/regfile_ctrl.md
REGFILE_CTRL -- requirements
Module: regfile_ctrl

Interface
REQ-001 SHALL have parameter: N, 4, data width of each of the 4 registers.
REQ-002 SHALL have port: Clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: iReq  input  2  request from requester k (bit k).
REQ-005 SHALL have port: iOp  input  2x2  opcode per requester: 00 READ, 01 WRITE, 10 COPY, 11 SWAP.
REQ-006 SHALL have port: iSrc  input  2x2  source register index per requester.
REQ-007 SHALL have port: iDst  input  2x2  destination register index per requester.
REQ-008 SHALL have port: iData  input  2xN  write data per requester.
REQ-009 SHALL have port: oGnt  output  2  one-hot owner of current operation; 0 when idle.
REQ-010 SHALL have port: oAck  output  2  one-cycle completion pulse to owner.
REQ-011 SHALL have port: oRdData  output  N  READ result, valid while oAck asserted.
REQ-012 SHALL have port: oBusy  output  1  high whenever not IDLE.
REQ-013 SHALL have port: oLoad  output  4  one-hot register-file write enable; at most one bit high.
REQ-014 SHALL have port: oWrData  output  N  register-file write data.
REQ-015 SHALL have port: oRdIdx  output  2  register-file read-mux select.
REQ-016 SHALL have port: iRdData  input  N  register-file read-mux output (combinational of oRdIdx).

Function
REQ-017 SHALL implement states IDLE, EX1, EX2, EX3.
REQ-018 In IDLE with any iReq bit set, SHALL grant one requester by round-robin, latch its op/src/dst/data, and enter EX1 next cycle.
REQ-019 Round-robin: both requesting -> grant pointer side; after any grant, pointer moves to the other requester; single requester always granted.
REQ-020 iReq SHALL be ignored outside IDLE; latched command SHALL not change until return to IDLE.
REQ-021 READ: EX1 drives oRdIdx=src, oRdData=iRdData, oAck; no oLoad.
REQ-022 WRITE: EX1 drives oLoad[dst], oWrData=latched data, oAck.
REQ-023 COPY: EX1 drives oRdIdx=src, oLoad[dst], oWrData=iRdData, oAck.
REQ-024 SWAP: EX1 oRdIdx=src, temp<=iRdData; EX2 oRdIdx=dst, oLoad[src], oWrData=iRdData; EX3 oLoad[dst], oWrData=temp, oAck.
REQ-025 Final exec cycle SHALL return to IDLE; latency grant-to-ack: 1 cycle (READ/WRITE/COPY), 3 cycles (SWAP); one IDLE cycle between operations.
REQ-026 Requester SHALL drop iReq in the cycle after oAck, else it is re-granted as a new request.
REQ-027 src==dst: COPY rewrites same value; SWAP runs all 3 cycles, register unchanged.
REQ-028 oGnt SHALL equal the latched owner in EX1..EX3; oBusy=1 in EX1..EX3.
REQ-029 Outside the cycles listed, oLoad, oAck SHALL be 0; oRdIdx, oWrData, oRdData SHALL be 0.

Reset
REQ-030 Reset SHALL force IDLE, pointer to requester 0, temp and latched command to 0, all outputs 0.
REQ-031 Reset in any exec state SHALL abort without oAck and without further oLoad; a SWAP reset in EX3 leaves src already overwritten.
REQ-032 Reset SHALL take priority over a simultaneous grant.

Structure
REQ-033 Package regfile_pkg SHALL hold the opcode enum, state enum, NUM_REGS=4, IDX_W=2.
REQ-034 Round-robin grant SHALL be sub-module rr_arbiter2 (iReq, update strobe, oGnt, internal pointer).

Verification
REQ-035 Req0 WRITE dst=2 data=0xA -> next cycle oLoad=0100, oWrData=0xA, oAck=01; R2=0xA.
REQ-036 R1=0x5, req1 READ src=1 -> oRdIdx=1, oRdData=0x5 with oAck=10, oLoad=0000.
REQ-037 Both requesting after reset -> grant order 0,1,0,1; each ack two cycles apart.
REQ-038 R0=0x3,R3=0xC, SWAP src=0 dst=3 -> EX2 oLoad=0001 data 0xC, EX3 oLoad=1000 data 0x3, ack in EX3.
REQ-039 COPY src=1 dst=1 and SWAP src=2 dst=2 -> register values unchanged, acks delivered.
REQ-040 Reset asserted in EX2 of SWAP -> no oAck, no oLoad afterwards, IDLE, pointer=0.
